// File: rtl/axi_dma_arb_pkg.sv
// Shared types for the DMA burst arbiter: default 1D burst request, order-tracker entry,
// and the outstanding-counter width helper.
package axi_dma_arb_pkg;

  localparam int unsigned MaxChanIdxW = 8;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] num_bytes;
  } burst_req_1d_t;

  typedef struct packed {
    logic [MaxChanIdxW-1:0] chan;
    logic                   empty;
  } trk_entry_t;

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/axi_dma_arb_tracker.sv
// Issue-order FIFO for the DMA burst arbiter. Zero-length entries retire on their own once
// they reach the head; all others wait for the backend's in-order completion strobe.
module axi_dma_arb_tracker
  import axi_dma_arb_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned ChanW = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  trk_entry_t       push_entry_i,
  input  logic             done_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             pop_o,
  output logic [ChanW-1:0] pop_chan_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = cnt_width(Depth);

  trk_entry_t      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  trk_entry_t      head;

  assign head       = mem_q[rd_ptr_q];
  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CntW'(Depth));
  assign pop_o      = !empty_o && (head.empty || done_i);
  assign pop_chan_o = head.chan[ChanW-1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_o) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_i && !pop_o)      count_q <= count_q + CntW'(1);
      else if (pop_o && !push_i) count_q <= count_q - CntW'(1);
    end
  end

  // A stray completion strobe is dropped, never held over for a later transfer.
  always @(posedge clk_i) begin
    if (rst_ni && done_i)
      assert (!empty_o && !head.empty)
        else $warning("done_i with no pending non-empty transfer; strobe ignored");
  end

endmodule

// File: rtl/axi_dma_burst_arbiter.sv
// Round-robin arbiter sharing one DMA backend burst port between NumChan frontends.
// Optional macro AXI_DMA_ARB_PRIO_EN adds prio_i: flagged requesters win over the rest.
module axi_dma_burst_arbiter
  import axi_dma_arb_pkg::*;
#(
  parameter int unsigned NumChan        = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter type         burst_req_t    = axi_dma_arb_pkg::burst_req_1d_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
`ifdef AXI_DMA_ARB_PRIO_EN
  input  logic [NumChan-1:0]         prio_i,
`endif
  input  burst_req_t [NumChan-1:0]   chan_req_i,
  input  logic [NumChan-1:0]         chan_valid_i,
  output logic [NumChan-1:0]         chan_ready_o,
  output burst_req_t                 burst_req_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  input  logic                       done_i,
  output logic [NumChan-1:0]         chan_done_o,
  output logic [NumChan-1:0]         chan_busy_o,
  output logic                       idle_o
);

  localparam int unsigned ChanW = (NumChan > 1) ? $clog2(NumChan) : 1;
  localparam int unsigned CntW  = cnt_width(MaxOutstanding);
  typedef logic [ChanW-1:0] chan_idx_t;

  chan_idx_t          rr_ptr_q, grant_idx, rr_next, pop_chan;
  logic [NumChan-1:0] eligible;
  logic               any_req, slot_free, grant;
  logic               fifo_full, fifo_empty, pop;
  logic [CntW-1:0]    cnt_q [NumChan];
  logic [CntW-1:0]    cnt_d [NumChan];
  logic [NumChan-1:0] cnt_ovf, cnt_unf;
  logic               stall_q;
  burst_req_t         held_req_q;

`ifdef AXI_DMA_ARB_PRIO_EN
  assign eligible = (|(chan_valid_i & prio_i)) ? (chan_valid_i & prio_i) : chan_valid_i;
`else
  assign eligible = chan_valid_i;
`endif

  assign slot_free = !valid_o || ready_i;
  assign grant     = rst_ni && slot_free && !fifo_full && any_req;
  assign idle_o    = !valid_o && fifo_empty;
  assign rr_next   = (grant_idx == chan_idx_t'(NumChan - 1)) ? '0 : grant_idx + ChanW'(1);

  // Scan starting at rr_ptr_q and wrap; the first eligible channel wins.
  always_comb begin
    logic [ChanW:0] cand;
    cand      = '0;
    any_req   = 1'b0;
    grant_idx = rr_ptr_q;
    for (int i = 0; i < int'(NumChan); i++) begin
      cand = {1'b0, rr_ptr_q} + (ChanW+1)'(i);
      if (cand >= (ChanW+1)'(NumChan)) cand = cand - (ChanW+1)'(NumChan);
      if (!any_req && eligible[cand[ChanW-1:0]]) begin
        any_req   = 1'b1;
        grant_idx = cand[ChanW-1:0];
      end
    end
  end

  always_comb begin
    chan_ready_o = '0;
    if (grant) chan_ready_o[grant_idx] = 1'b1;
  end

  // A channel granted and retired in the same cycle keeps its count.
  always_comb begin
    cnt_ovf = '0;
    cnt_unf = '0;
    for (int c = 0; c < int'(NumChan); c++) begin
      cnt_d[c] = cnt_q[c];
      if (grant && grant_idx == chan_idx_t'(c) && !(pop && pop_chan == chan_idx_t'(c))) begin
        cnt_d[c]   = cnt_q[c] + CntW'(1);
        cnt_ovf[c] = (cnt_q[c] == CntW'(MaxOutstanding));
      end else if (pop && pop_chan == chan_idx_t'(c) && !(grant && grant_idx == chan_idx_t'(c))) begin
        cnt_d[c]   = cnt_q[c] - CntW'(1);
        cnt_unf[c] = (cnt_q[c] == '0);
      end
    end
  end

  axi_dma_arb_tracker #(
    .Depth (MaxOutstanding),
    .ChanW (ChanW)
  ) i_tracker (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (grant),
    .push_entry_i ('{chan: MaxChanIdxW'(grant_idx), empty: (chan_req_i[grant_idx].num_bytes == '0)}),
    .done_i       (done_i),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .pop_o        (pop),
    .pop_chan_o   (pop_chan)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_o     <= 1'b0;
      burst_req_o <= '0;
      rr_ptr_q    <= '0;
      chan_done_o <= '0;
      chan_busy_o <= '0;
      for (int c = 0; c < int'(NumChan); c++) cnt_q[c] <= '0;
    end else begin
      if (slot_free) begin
        valid_o <= grant;
        if (grant) burst_req_o <= chan_req_i[grant_idx];
      end
      if (grant) rr_ptr_q <= rr_next;
      chan_done_o <= '0;
      if (pop) chan_done_o[pop_chan] <= 1'b1;
      for (int c = 0; c < int'(NumChan); c++) begin
        cnt_q[c]       <= cnt_d[c];
        chan_busy_o[c] <= (cnt_d[c] != '0);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    stall_q    <= rst_ni && valid_o && !ready_i;
    held_req_q <= burst_req_o;
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert ($onehot0(chan_ready_o));
      assert (cnt_ovf == '0 && cnt_unf == '0);
      if (stall_q) assert (burst_req_o == held_req_q);
    end
  end

endmodule
